// File: rtl/calc_serial_pkg.sv
// Shared types and line levels for the calculator serial transmitter.
// Optional parity state is present only when CALC_SERIAL_TX_PARITY_EN is defined.
package calc_serial_pkg;

`ifdef CALC_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} ser_state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;
`endif

    localparam logic SER_START_BIT  = 1'b0;
    localparam logic SER_STOP_BIT   = 1'b1;
    localparam logic SER_IDLE_LEVEL = 1'b1;

    // Counter width that still works for a count range of one.
    function automatic int ser_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/calc_serial_tx_if.sv
// Controller-side handshake and serial line of the calculator transmitter.
interface calc_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              p_load;
    logic              tx_dat;
    logic [DATA_W-1:0] data_in;
    logic              tx_out;
    logic              tx_done;

    modport master (output p_load, tx_dat, data_in, input tx_out, tx_done);
    modport slave  (input p_load, tx_dat, data_in, output tx_out, tx_done);
endinterface

// File: rtl/calc_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each bit.
module serial_bit_timer
    import calc_serial_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_end_o
);
    localparam int CW = ser_cnt_w(BIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last      = (cnt_q == CW'(BIT_CYCLES - 1));
    assign bit_end_o = last && !clear_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || last) cnt_d = '0;
        else                 cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/calc_serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, stop bit.
// Define CALC_SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module calc_serial_tx
    import calc_serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    calc_serial_tx_if.slave  bus
);
    localparam int IW = ser_cnt_w(DATA_W);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;
    logic              bit_end;

    serial_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = bus.p_load ? bus.data_in : hold_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_out_d  = tx_out_q;
        tx_done_d = tx_done_q;
        case (state_q)
            ST_IDLE: begin
                tx_out_d  = SER_IDLE_LEVEL;
                tx_done_d = 1'b1;
                if (bus.tx_dat) begin
                    // Load bypass: a same-cycle p_load wins over the stale holding word.
                    state_d   = ST_START;
                    shift_d   = bus.p_load ? bus.data_in : hold_q;
                    tx_out_d  = SER_START_BIT;
                    tx_done_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d  = ST_DATA;
                    idx_d    = '0;
                    tx_out_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    // Rotate so the full word is intact again after the last bit.
                    shift_d = (shift_q >> 1) | (shift_q << (DATA_W - 1));
                    if (idx_q == IW'(DATA_W - 1)) begin
                        idx_d = '0;
`ifdef CALC_SERIAL_TX_PARITY_EN
                        state_d  = ST_PAR;
                        tx_out_d = ^shift_q;
`else
                        state_d  = ST_STOP;
                        tx_out_d = SER_STOP_BIT;
`endif
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        tx_out_d = shift_d[0];
                    end
                end
            end
`ifdef CALC_SERIAL_TX_PARITY_EN
            ST_PAR: begin
                if (bit_end) begin
                    state_d  = ST_STOP;
                    tx_out_d = SER_STOP_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d   = ST_IDLE;
                    tx_out_d  = SER_IDLE_LEVEL;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tx_out_d  = SER_IDLE_LEVEL;
                tx_done_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            tx_out_q  <= SER_IDLE_LEVEL;
            tx_done_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign bus.tx_out  = tx_out_q;
    assign bus.tx_done = tx_done_q;
endmodule

// File: doc/calc_serial_tx.md
# calc_serial_tx

Serial transmitter answering the calculator's read/write flow controller. It accepts a parallel result word on `p_load`, serializes it onto a single line as one framed word when `tx_dat` is pulsed, and reports readiness back to the controller on `tx_done`. It sits between the controller/memory read path and the external serial output pin.

## Interface

- `DATA_W`, default 8: payload width in bits.
- `BIT_CYCLES`, default 4: clock cycles each serial bit is held; legal values are 1 or more.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `p_load`  in  1  captures `data_in` into the holding register.
- `tx_dat`  in  1  one-cycle start-frame request.
- `data_in`  in  DATA_W  word to transmit.
- `tx_out`  out  1  serial line; idles high.
- `tx_done`  out  1  high when idle and ready to start a frame; low while a frame is in flight.

## Operation

- Frame format, in transmission order:
  - start bit 0;
  - DATA_W data bits, LSB first;
  - parity bit, only when the configuration macro is defined;
  - stop bit 1.
- State machine: IDLE, START, DATA, PAR, STOP.
  - IDLE: go to START when `tx_dat`=1.
  - START: go to DATA after BIT_CYCLES cycles.
  - DATA: go to PAR, or to STOP when parity is compiled out, after DATA_W bit periods.
  - PAR: go to STOP after BIT_CYCLES cycles.
  - STOP: go to IDLE after BIT_CYCLES cycles.
- Holding register:
  - `p_load`=1 writes `data_in` into it in any state.
  - Leaving IDLE copies it into the shift register.
- `p_load` and `tx_dat` in the same IDLE cycle: the frame carries that cycle's `data_in` (load bypass).
- `tx_dat` outside IDLE is ignored and is not queued.
- `p_load` during a frame updates only the holding register. The word in flight is unchanged.
- Internal counters:
  - A cycle counter of width max(1, clog2(BIT_CYCLES)) counts 0..BIT_CYCLES-1 and wraps to 0 at the end of each bit.
  - A bit index counts 0..DATA_W-1 within DATA.
- Reset (`reset`=0 at a rising edge), including mid-frame, sets:
  - state to IDLE;
  - `tx_out`=1 and `tx_done`=1;
  - counters to 0;
  - holding and shift registers to 0.

## Timing

- `tx_out` and `tx_done` are registered; there are no combinational paths from inputs to outputs.
- Request at cycle T: at T+1, `tx_out`=0 (start bit) and `tx_done`=0.
- Frame length F = (DATA_W + 2 + P) × BIT_CYCLES cycles, where P=1 if parity is compiled in, else 0.
- `tx_done` rises at T+1+F, the first IDLE cycle, with `tx_out`=1.
- A `tx_done`=0 indication is visible to the controller from T+1 onward, before it samples it in its wait state.
- Back-to-back frames: `tx_dat` in the first cycle of `tx_done`=1 starts the next start bit one cycle later. The minimum gap is the stop bit plus one idle cycle.

## Configuration

- `CALC_SERIAL_TX_PARITY_EN` defined:
  - the PAR state exists;
  - the parity bit is XOR-reduce of the transmitted word, giving even parity over data plus parity;
  - F includes P=1.
- Not defined:
  - PAR is absent and DATA goes straight to STOP;
  - F uses P=0;
  - the interface is unchanged.

## Structure

- Shared package `calc_serial_pkg` holds:
  - the state enum;
  - `SER_START_BIT` = 1'b0;
  - `SER_STOP_BIT` = 1'b1;
  - `SER_IDLE_LEVEL` = 1'b1.
- Sub-module `serial_bit_timer`:
  - contains the BIT_CYCLES cycle counter;
  - has a clear input;
  - emits a one-cycle `bit_end` pulse on the last cycle of each bit period.
- All other logic (FSM, shift register, holding register) lives in the top module.

## Test plan

All scenarios use DATA_W=8 and BIT_CYCLES=4.

- Reset: hold `reset`=0 for 2 cycles with random inputs -> `tx_out`=1, `tx_done`=1; no frame starts.
- `p_load`=1, `tx_dat`=1, `data_in`=8'hA5 in the same cycle:
  - `tx_out` carries 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles;
  - `tx_done` is low for 40 cycles and high on cycle 41;
  - with parity: bit 0 is inserted before stop, 44 cycles total.
- `p_load` with 8'h3C, then `tx_dat` 3 cycles later while `data_in`=8'hFF -> the serialized payload is 8'h3C.
- Mid-frame `tx_dat` plus `p_load` with 8'h0F during DATA:
  - the current frame is unaltered and exactly one frame is sent;
  - the next `tx_dat` after `tx_done` rises sends 8'h0F.
- `reset`=0 at cycle 10 of a frame -> next cycle `tx_out`=1, `tx_done`=1; a following `tx_dat` without `p_load` sends 8'h00.
- Back-to-back: `tx_dat` on the first `tx_done`=1 cycle -> the start bit appears the next cycle and the second frame is correct.
